// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/func
// constants, ALU control codes, memctrl/muxctrl bit positions, state
// encoding and the DECODE dispatch helper.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_MEMADDR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // memctrl bit indices
  localparam int unsigned MC_REG_WR = 0;
  localparam int unsigned MC_MEM_WR = 1;
  localparam int unsigned MC_MEM_RD = 2;

  // muxctrl bit indices
  localparam int unsigned MX_REG_DST    = 0;
  localparam int unsigned MX_MEM_TO_REG = 1;
  localparam int unsigned MX_IORD       = 2;
  localparam int unsigned MX_SRC_A      = 3;
  localparam int unsigned MX_SRCB_LO    = 4;
  localparam int unsigned MX_SRCB_HI    = 5;
  localparam int unsigned MX_IR_WRITE   = 6;

  // alu_src_b selections
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // pc_src selections
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_alu_func(input logic [5:0] func);
    logic ok;
    ok = 1'b0;
    case (func)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Successor of DECODE; unsupported op/func combinations go to TRAP.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] func);
    state_t s;
    s = S_TRAP;
    case (op)
      OP_RTYPE:     if (is_alu_func(func)) s = S_EXEC_R;
      OP_LW, OP_SW: s = S_MEMADDR;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = S_JUMP;
      OP_ADDI:      s = S_EXEC_I;
      default:      s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer and the MIPS datapath.
//   op, func, zero, mem_ready : datapath/memory -> controller
//   memctrl, aluctrl, muxctrl,
//   pc_write, pc_src          : controller -> datapath/memory
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic [2:0] memctrl;
  logic [3:0] aluctrl;
  logic [6:0] muxctrl;
  logic       pc_write;
  logic [1:0] pc_src;

  modport master (
    input  op, func, zero, mem_ready,
    output memctrl, aluctrl, muxctrl, pc_write, pc_src
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  memctrl, aluctrl, muxctrl, pc_write, pc_src
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type function field to ALU control decode (combinational).
//   func_i    : IR[5:0]
//   aluctrl_o : ALU operation code
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [3:0] aluctrl_o
);

  always_comb begin
    aluctrl_o = ALU_PASS;
    case (func_i)
      FN_ADD, FN_ADDU: aluctrl_o = ALU_ADD;
      FN_SUB, FN_SUBU: aluctrl_o = ALU_SUB;
      FN_AND:          aluctrl_o = ALU_AND;
      FN_OR:           aluctrl_o = ALU_OR;
      FN_NOR:          aluctrl_o = ALU_NOR;
      default:         aluctrl_o = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: FETCH, DECODE, EXEC,
// MEM and WB steps, memory-ready handshake with timeout, sticky trap.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : multicycle_ctrl_if.master (op/func/zero/mem_ready in,
//                memctrl/aluctrl/muxctrl/pc_write/pc_src out)
//   trap       : sticky error flag (TRAP state)
//   state_dbg  : current state encoding
//   cycle_cnt, instr_cnt : perf counters, only with MC_PERF_CNT_EN
// Parameters: MEM_TIMEOUT (1..65535), CNT_W (perf counter width).
// Optional feature macro: MC_PERF_CNT_EN.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus,
  output logic                 trap,
  output logic [3:0]           state_dbg
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instr_cnt
`endif
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        in_mem_state;
  logic        wait_expired;
  logic [3:0]  rtype_alu;

  logic [2:0]  memctrl_c;
  logic [3:0]  aluctrl_c;
  logic [6:0]  muxctrl_c;
  logic        pc_write_c;
  logic [1:0]  pc_src_c;

  alu_decoder u_alu_decoder (
    .func_i    (bus.func),
    .aluctrl_o (rtype_alu)
  );

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);
  // wait_q counts completed wait cycles, so the current cycle is number
  // wait_q+1; a late mem_ready on the final allowed cycle still wins.
  assign wait_expired = (wait_q == WAIT_LAST) && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)     state_d = S_DECODE;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_DECODE:  state_d = dispatch(bus.op, bus.func);
      S_EXEC_R:  state_d = S_WB_R;
      S_WB_R:    state_d = S_FETCH;
      S_EXEC_I:  state_d = S_WB_I;
      S_WB_I:    state_d = S_FETCH;
      S_MEMADDR: state_d = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready)     state_d = S_WB_MEM;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_WB_MEM:  state_d = S_FETCH;
      S_MEM_WR: begin
        if (bus.mem_ready)     state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
    if (in_mem_state && (state_d == state_q)) wait_d = wait_q + 16'd1;
  end

  always_comb begin
    memctrl_c  = '0;
    aluctrl_c  = ALU_AND;
    muxctrl_c  = '0;
    pc_write_c = 1'b0;
    pc_src_c   = PC_ALU;
    case (state_q)
      S_FETCH: begin
        memctrl_c[MC_MEM_RD]                = 1'b1;
        aluctrl_c                           = ALU_ADD;
        muxctrl_c[MX_SRCB_HI:MX_SRCB_LO]    = SRCB_FOUR;
        if (bus.mem_ready) begin
          muxctrl_c[MX_IR_WRITE] = 1'b1;
          pc_write_c             = 1'b1;
        end
      end
      S_DECODE: begin
        aluctrl_c                        = ALU_ADD;
        muxctrl_c[MX_SRCB_HI:MX_SRCB_LO] = SRCB_IMM;
      end
      S_EXEC_R: begin
        aluctrl_c                        = rtype_alu;
        muxctrl_c[MX_SRC_A]              = 1'b1;
        muxctrl_c[MX_SRCB_HI:MX_SRCB_LO] = SRCB_REG;
      end
      S_WB_R: begin
        memctrl_c[MC_REG_WR]  = 1'b1;
        muxctrl_c[MX_REG_DST] = 1'b1;
      end
      S_EXEC_I, S_MEMADDR: begin
        aluctrl_c                        = ALU_ADD;
        muxctrl_c[MX_SRC_A]              = 1'b1;
        muxctrl_c[MX_SRCB_HI:MX_SRCB_LO] = SRCB_IMM;
      end
      S_WB_I: begin
        memctrl_c[MC_REG_WR] = 1'b1;
      end
      S_MEM_RD: begin
        memctrl_c[MC_MEM_RD] = 1'b1;
        muxctrl_c[MX_IORD]   = 1'b1;
      end
      S_WB_MEM: begin
        memctrl_c[MC_REG_WR]     = 1'b1;
        muxctrl_c[MX_MEM_TO_REG] = 1'b1;
      end
      S_MEM_WR: begin
        memctrl_c[MC_MEM_WR] = 1'b1;
        muxctrl_c[MX_IORD]   = 1'b1;
      end
      S_BRANCH: begin
        aluctrl_c           = ALU_SUB;
        muxctrl_c[MX_SRC_A] = 1'b1;
        pc_src_c            = PC_BRANCH;
        pc_write_c          = bus.zero;
      end
      S_JUMP: begin
        pc_src_c   = PC_JUMP;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every output combinationally so memory control drops in
  // the cycle reset is asserted, not one cycle later.
  assign bus.memctrl  = reset ? '0 : memctrl_c;
  assign bus.aluctrl  = reset ? '0 : aluctrl_c;
  assign bus.muxctrl  = reset ? '0 : muxctrl_c;
  assign bus.pc_write = reset ? 1'b0 : pc_write_c;
  assign bus.pc_src   = reset ? '0 : pc_src_c;
  assign trap         = !reset && (state_q == S_TRAP);
  assign state_dbg    = reset ? '0 : state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q <= cycle_q + 1'b1;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_q <= instr_q + 1'b1;
    end
  end

  assign cycle_cnt = reset ? '0 : cycle_q;
  assign instr_cnt = reset ? '0 : instr_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (MEM_TIMEOUT=4).
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       trap;
  logic [3:0] state_dbg;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  int n_checks;
  int n_errors;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .trap      (trap),
    .state_dbg (state_dbg)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_state(input string tag, input state_t s);
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  // Table of R-type funcs and the aluctrl expected in EXEC_R.
  logic [5:0] rt_func [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100001, 6'b100011};
  logic [3:0] rt_alu  [6] = '{4'b0110,   4'b0000,   4'b0001,   4'b1100,   4'b0010,   4'b0110};

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.op = 6'b0;
    bus.func = 6'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    // Outputs forced to zero while reset is held
    #1;
    chk("rst_memctrl", 32'(bus.memctrl), 0);
    chk("rst_muxctrl", 32'(bus.muxctrl), 0);
    chk("rst_pcwrite", 32'(bus.pc_write), 0);
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk_state("rst_state", S_FETCH);
    chk("rst_trap", 32'(trap), 0);

    // ADD, zero-wait memory
    bus.op = 6'b000000;
    bus.func = 6'b100000;
    settle();
    chk("add_f_mem", 32'(bus.memctrl), 'h4);
    chk("add_f_mux", 32'(bus.muxctrl), 'h50);
    chk("add_f_pcw", 32'(bus.pc_write), 1);
    chk("add_f_alu", 32'(bus.aluctrl), 'h2);
    tick();
    chk_state("add_d_st", S_DECODE);
    chk("add_d_mux", 32'(bus.muxctrl), 'h20);
    chk("add_d_mem", 32'(bus.memctrl), 0);
    tick();
    chk_state("add_e_st", S_EXEC_R);
    chk("add_e_alu", 32'(bus.aluctrl), 'h2);
    chk("add_e_mux", 32'(bus.muxctrl), 'h08);
    chk("add_e_mem", 32'(bus.memctrl), 0);
    tick();
    chk_state("add_wb_st", S_WB_R);
    chk("add_wb_mem", 32'(bus.memctrl), 'h1);
    chk("add_wb_mux", 32'(bus.muxctrl), 'h01);
    tick();
    chk_state("add_back", S_FETCH);

    // Remaining R-type funcs
    for (int i = 0; i < 6; i++) begin
      bus.func = rt_func[i];
      tick();
      tick();
      chk_state("rt_exec_st", S_EXEC_R);
      chk("rt_exec_alu", 32'(bus.aluctrl), 32'(rt_alu[i]));
      tick();
      tick();
      chk_state("rt_back", S_FETCH);
    end

    // ADDI
    bus.op = 6'b001000;
    tick();
    tick();
    chk_state("addi_e_st", S_EXEC_I);
    chk("addi_e_mux", 32'(bus.muxctrl), 'h28);
    chk("addi_e_alu", 32'(bus.aluctrl), 'h2);
    tick();
    chk_state("addi_wb_st", S_WB_I);
    chk("addi_wb_mem", 32'(bus.memctrl), 'h1);
    chk("addi_wb_mux", 32'(bus.muxctrl), 'h00);
    tick();
    chk_state("addi_back", S_FETCH);

    // LW with three wait cycles in MEM_RD (mem_ready on the timeout cycle)
    bus.op = 6'b100011;
    tick();
    tick();
    chk_state("lw_ma_st", S_MEMADDR);
    chk("lw_ma_mux", 32'(bus.muxctrl), 'h28);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      settle();
      chk_state("lw_rd_st", S_MEM_RD);
      chk("lw_rd_mem", 32'(bus.memctrl), 'h4);
      chk("lw_rd_mux", 32'(bus.muxctrl), 'h04);
      tick();
    end
    chk_state("lw_wb_st", S_WB_MEM);
    chk("lw_wb_mux", 32'(bus.muxctrl), 'h02);
    chk("lw_wb_mem", 32'(bus.memctrl), 'h1);
    tick();
    chk_state("lw_back", S_FETCH);

    // SW zero-wait
    bus.op = 6'b101011;
    tick();
    tick();
    tick();
    chk_state("sw_wr_st", S_MEM_WR);
    chk("sw_wr_mem", 32'(bus.memctrl), 'h2);
    chk("sw_wr_mux", 32'(bus.muxctrl), 'h04);
    tick();
    chk_state("sw_back", S_FETCH);

    // BEQ taken then not taken
    bus.op = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      tick();
      tick();
      bus.zero = (i == 0);
      settle();
      chk_state("beq_st", S_BRANCH);
      chk("beq_pcw", 32'(bus.pc_write), (i == 0) ? 1 : 0);
      chk("beq_pcsrc", 32'(bus.pc_src), 'h1);
      chk("beq_alu", 32'(bus.aluctrl), 'h6);
      tick();
      chk_state("beq_back", S_FETCH);
    end
    bus.zero = 1'b0;

    // J
    bus.op = 6'b000010;
    tick();
    tick();
    chk_state("j_st", S_JUMP);
    chk("j_pcsrc", 32'(bus.pc_src), 'h2);
    chk("j_pcw", 32'(bus.pc_write), 1);
    tick();
    chk_state("j_back", S_FETCH);

    // FETCH timeout: four cycles without mem_ready
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_state("to_fetch_st", S_FETCH);
      chk("to_fetch_pcw", 32'(bus.pc_write), 0);
      tick();
    end
    chk_state("to_trap_st", S_TRAP);
    chk("to_trap", 32'(trap), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk_state("to_rst_st", S_FETCH);

    // mem_ready on the 4th FETCH cycle avoids the trap
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      tick();
    end
    chk_state("to_late_st", S_DECODE);
    chk("to_late_trap", 32'(trap), 0);
    tick();
    tick();
    chk_state("to_late_back", S_FETCH);

    // Illegal R-type func traps
    bus.mem_ready = 1'b1;
    bus.op = 6'b000000;
    bus.func = 6'b000000;
    tick();
    tick();
    chk_state("badfn_st", S_TRAP);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Illegal opcode: trap holds through mem_ready toggling
    bus.op = 6'b111111;
    tick();
    tick();
    chk_state("ill_st", S_TRAP);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      tick();
      chk("ill_trap_hold", 32'(trap), 1);
      chk("ill_mem_zero", 32'(bus.memctrl), 0);
    end
    reset = 1'b1;
    settle();
    chk("ill_rst_trap", 32'(trap), 0);
    chk("ill_rst_dbg", 32'(state_dbg), 0);
    chk("ill_rst_mem", 32'(bus.memctrl), 0);
    tick();
    reset = 1'b0;
    settle();
    chk_state("ill_after_st", S_FETCH);

    // Reset asserted while waiting in MEM_WR, then J
    bus.mem_ready = 1'b1;
    bus.op = 6'b101011;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    settle();
    chk("mw_mem", 32'(bus.memctrl), 'h2);
    reset = 1'b1;
    settle();
    chk("mw_rst_mem", 32'(bus.memctrl), 0);
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op = 6'b000010;
    settle();
    chk_state("mw_after_st", S_FETCH);
    tick();
    tick();
    chk_state("mw_j_st", S_JUMP);
    chk("mw_j_pcsrc", 32'(bus.pc_src), 'h2);
    chk("mw_j_pcw", 32'(bus.pc_write), 1);
    tick();
    chk_state("mw_j_back", S_FETCH);
`ifdef MC_PERF_CNT_EN
    chk("perf_instr", instr_cnt, 1);
    chk("perf_cycle", cycle_cnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
